// File: rtl/wb_regfile.sv
// ============================================================================
// wb_regfile : writeback decode, 32x32 register file with write-through
//              read ports, and retired-instruction counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] o_in,
  input  logic [31:0] d_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] ins_in,
  input  logic        ovf_in,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [31:0] retired_count
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;

  localparam logic [4:0] FN_ADD = 5'b00000;
  localparam logic [4:0] FN_SUB = 5'b00001;
  localparam logic [4:0] FN_MUL = 5'b00110;
  localparam logic [4:0] FN_DIV = 5'b00111;

  logic [31:0] regs [32];
  logic [31:0] count_q;

  logic [4:0]  opcode;
  logic [4:0]  aluop;
  logic        is_rtype;
  logic        is_nop;
  logic        dec_we;
  logic [4:0]  dec_rd;
  logic [31:0] dec_data;
  logic [2:0]  ovf_code;

  assign opcode   = ins_in[31:27];
  assign aluop    = ins_in[6:2];
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_nop   = (ins_in == 32'd0);

  // Overflow codes in priority order; 0 means the overflow flag is ignored.
  always_comb begin
    ovf_code = 3'd0;
    if (ovf_in && !is_nop) begin
      if (is_rtype && aluop == FN_ADD)      ovf_code = 3'd1;
      else if (opcode == OP_ADDI)           ovf_code = 3'd2;
      else if (is_rtype && aluop == FN_SUB) ovf_code = 3'd3;
      else if (is_rtype && aluop == FN_MUL) ovf_code = 3'd4;
      else if (is_rtype && aluop == FN_DIV) ovf_code = 3'd5;
    end
  end

  always_comb begin
    dec_we   = 1'b0;
    dec_rd   = ins_in[26:22];
    dec_data = o_in;
    if (is_nop) begin
      dec_we = 1'b0;
    end else if (ovf_code != 3'd0) begin
      dec_we   = 1'b1;
      dec_rd   = 5'd30;
      dec_data = {29'd0, ovf_code};
    end else begin
      case (opcode)
        OP_RTYPE, OP_ADDI: begin
          dec_we   = 1'b1;
          dec_data = o_in;
        end
        OP_LW: begin
          dec_we   = 1'b1;
          dec_data = d_in;
        end
        OP_JAL: begin
          dec_we   = 1'b1;
          dec_rd   = 5'd31;
          dec_data = pc_in + 32'd1;
        end
        OP_SETX: begin
          dec_we   = 1'b1;
          dec_rd   = 5'd30;
          dec_data = {5'd0, ins_in[26:0]};
        end
        default: dec_we = 1'b0;
      endcase
    end
  end

  // r0 writes and anything presented during reset are suppressed at the source
  // so the bypass path never exposes them.
  assign wb_we   = dec_we && (dec_rd != 5'd0) && resetn;
  assign wb_rd   = dec_rd;
  assign wb_data = dec_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     count_q <= 32'd0;
    else if (!is_nop) count_q <= count_q + 32'd1;
  end

  assign retired_count = count_q;

  always_comb begin
    rs1_data = regs[rs1_addr];
    if (rs1_addr == 5'd0)                   rs1_data = 32'd0;
    else if (wb_we && rs1_addr == wb_rd)    rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    if (rs2_addr == 5'd0)                   rs2_data = 32'd0;
    else if (wb_we && rs2_addr == wb_rd)    rs2_data = wb_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// tb_wb_regfile : scoreboard bench for wb_regfile against a reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

  logic        clk;
  logic        resetn;
  logic [31:0] o_in, d_in, pc_in, ins_in;
  logic        ovf_in;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data, retired_count;
  logic        wb_we;
  logic [4:0]  wb_rd;

  wb_regfile dut (
    .clk(clk), .resetn(resetn), .o_in(o_in), .d_in(d_in), .pc_in(pc_in),
    .ins_in(ins_in), .ovf_in(ovf_in), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] mregs [32];
  logic [31:0] mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural meaning of one latched instruction.
  task automatic ref_decode(input logic [31:0] ins, input logic [31:0] o, input logic [31:0] d,
                            input logic [31:0] pc, input logic ovf,
                            output logic we, output logic [4:0] rd, output logic [31:0] data);
    logic [4:0] op, fu;
    int code;
    op = ins[31:27]; fu = ins[6:2];
    we = 1'b0; rd = ins[26:22]; data = 32'd0; code = 0;
    if (ins != 32'd0) begin
      if (ovf) begin
        if (op == 5'd0 && fu == 5'd0)      code = 1;
        else if (op == 5'd5)               code = 2;
        else if (op == 5'd0 && fu == 5'd1) code = 3;
        else if (op == 5'd0 && fu == 5'd6) code = 4;
        else if (op == 5'd0 && fu == 5'd7) code = 5;
      end
      if (code != 0) begin
        we = 1'b1; rd = 5'd30; data = 32'(code);
      end else if (op == 5'd0 || op == 5'd5) begin
        we = 1'b1; data = o;
      end else if (op == 5'd8) begin
        we = 1'b1; data = d;
      end else if (op == 5'd3) begin
        we = 1'b1; rd = 5'd31; data = pc + 32'd1;
      end else if (op == 5'd21) begin
        we = 1'b1; rd = 5'd30; data = {5'd0, ins[26:0]};
      end
    end
    if (rd == 5'd0) we = 1'b0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                        input logic [4:0] rd, input logic [31:0] data);
    if (a == 5'd0) return 32'd0;
    if (we && a == rd) return data;
    return mregs[a];
  endfunction

  // Present one cycle's inputs at the falling edge, queue the expected view,
  // then advance the model as the coming rising edge will.
  task automatic step(input logic rn, input logic [31:0] ins, input logic [31:0] o,
                      input logic [31:0] d, input logic [31:0] pc, input logic ovf,
                      input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    logic we; logic [4:0] rd; logic [31:0] data;
    @(negedge clk);
    resetn = rn; ins_in = ins; o_in = o; d_in = d; pc_in = pc; ovf_in = ovf;
    rs1_addr = a1; rs2_addr = a2;
    ref_decode(ins, o, d, pc, ovf, we, rd, data);
    if (!rn) begin
      we = 1'b0;
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      mcnt = 32'd0;
    end
    e.we = we; e.rd = rd; e.data = data;
    e.r1 = mread(a1, we, rd, data);
    e.r2 = mread(a2, we, rd, data);
    e.cnt = mcnt;
    sb.push_back(e);
    if (rn) begin
      if (we) mregs[rd] = data;
      if (ins != 32'd0) mcnt = mcnt + 32'd1;
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] fu);
    return {op, rd, 15'h1234 & 15'h7f80, fu, 2'b00};
  endfunction

  // Monitor: samples well after the falling-edge drive, well before the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
        if (e.we) begin
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
          chk("wb_data", wb_data, e.data);
        end
        chk("rs1_data", rs1_data, e.r1);
        chk("rs2_data", rs2_data, e.r2);
        chk("retired_count", retired_count, e.cnt);
      end
    end
  end

  initial begin
    logic [4:0] ops [12];
    logic [4:0] fus [5];
    logic [31:0] ins;
    logic [4:0]  a1, a2;
    ops = '{5'd0, 5'd5, 5'd8, 5'd3, 5'd21, 5'd7, 5'd1, 5'd2, 5'd4, 5'd6, 5'd22, 5'd31};
    fus = '{5'd0, 5'd1, 5'd6, 5'd7, 5'd3};
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt = 32'd0;
    resetn = 1'b0; ins_in = 32'd0; o_in = 32'd0; d_in = 32'd0; pc_in = 32'd0;
    ovf_in = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;

    step(1'b0, mk(5'd5, 5'd4, 5'd0), 32'd9, 32'd0, 32'd0, 1'b0, 5'd4, 5'd0);
    step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd1, 5'd31);
    // Release straight into addi r5 <- 7, visible the same cycle and after.
    step(1'b1, mk(5'd5, 5'd5, 5'd0), 32'd7, 32'd0, 32'd0, 1'b0, 5'd5, 5'd0);
    step(1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd5, 5'd5);
    // Overflow priority ladder.
    step(1'b1, mk(5'd0, 5'd3, 5'd0), 32'h8000_0000, 32'd0, 32'd0, 1'b1, 5'd30, 5'd3);
    step(1'b1, mk(5'd5, 5'd3, 5'd0), 32'h11, 32'd0, 32'd0, 1'b1, 5'd30, 5'd3);
    step(1'b1, mk(5'd0, 5'd3, 5'd1), 32'h22, 32'd0, 32'd0, 1'b1, 5'd30, 5'd3);
    step(1'b1, mk(5'd0, 5'd3, 5'd6), 32'h33, 32'd0, 32'd0, 1'b1, 5'd30, 5'd3);
    step(1'b1, mk(5'd0, 5'd3, 5'd7), 32'h44, 32'd0, 32'd0, 1'b1, 5'd30, 5'd3);
    step(1'b1, mk(5'd0, 5'd3, 5'd3), 32'h55, 32'd0, 32'd0, 1'b1, 5'd30, 5'd3);
    // jal wrap, setx, lw, then non-writing opcodes aimed at r9.
    step(1'b1, mk(5'd3, 5'd7, 5'd0), 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 5'd31, 5'd7);
    step(1'b1, {5'd21, 27'h7FF_FFFF}, 32'd0, 32'd0, 32'd0, 1'b0, 5'd30, 5'd31);
    step(1'b1, mk(5'd8, 5'd9, 5'd0), 32'h1234, 32'hDEAD_BEEF, 32'd0, 1'b0, 5'd9, 5'd30);
    step(1'b1, mk(5'd7, 5'd9, 5'd0), 32'h99, 32'h98, 32'h97, 1'b0, 5'd9, 5'd9);
    step(1'b1, mk(5'd2, 5'd9, 5'd0), 32'h99, 32'h98, 32'h97, 1'b0, 5'd9, 5'd9);
    step(1'b1, mk(5'd1, 5'd9, 5'd0), 32'h99, 32'h98, 32'h97, 1'b0, 5'd9, 5'd9);
    // r0 write is dropped; both ports on the same bypassed register.
    step(1'b1, mk(5'd5, 5'd0, 5'd0), 32'd5, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    step(1'b1, mk(5'd0, 5'd12, 5'd2), 32'hCAFE_F00D, 32'd0, 32'd0, 1'b0, 5'd12, 5'd12);

    for (int n = 0; n < 500; n++) begin
      ins = $urandom;
      ins[31:27] = ops[$urandom_range(11)];
      ins[6:2]   = fus[$urandom_range(4)];
      if ($urandom_range(4) == 0) ins = 32'd0;
      a1 = ($urandom_range(2) == 0) ? ins[26:22] : 5'($urandom);
      a2 = ($urandom_range(3) == 0) ? a1 : 5'($urandom);
      if ($urandom_range(5) == 0) a1 = 5'd30;
      step(($urandom_range(60) != 0), ins, $urandom, $urandom,
           ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom,
           ($urandom_range(3) == 0), a1, a2);
    end

    // Mid-cycle reset with a pending write, then readback of a few registers.
    step(1'b0, mk(5'd5, 5'd6, 5'd0), 32'd77, 32'd0, 32'd0, 1'b0, 5'd6, 5'd30);
    step(1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd6, 5'd31);

    @(negedge clk);
    #5;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file at the far end of the memory/writeback pipeline latch. It consumes the latched ALU result, load data, PC, instruction word and overflow flag, and decodes what gets written and where. It performs the register write and serves the two decode-stage read ports, with same-cycle write-through. It also maintains a retired-instruction counter.

## Interface

- No parameters. Data width is fixed at 32 bits; there are 32 registers.

Ports:

- clk  in  1  pipeline clock; all state updates on the rising edge
- resetn  in  1  asynchronous, active-low reset
- o_in  in  32  latched ALU result
- d_in  in  32  latched load data
- pc_in  in  32  latched PC of the instruction
- ins_in  in  32  latched instruction word; 0 is a nop
- ovf_in  in  1  latched ALU overflow flag
- rs1_addr, rs2_addr  in  5  read addresses from decode
- rs1_data, rs2_data  out  32  read data (combinational)
- wb_we  out  1  a register write happens this cycle (combinational); used for bypass
- wb_rd  out  5  destination register this cycle (combinational)
- wb_data  out  32  data being written this cycle (combinational)
- retired_count  out  32  count of non-nop instructions written back

## Operation

- Decode fields: opcode = ins_in[31:27], rd = [26:22], aluop = [6:2], T = [26:0].
- Write selection, highest priority first:
  - ovf_in=1 with R-type add (op 00000, aluop 00000): r30 ← 1.
  - ovf_in=1 with addi (op 00101): r30 ← 2.
  - ovf_in=1 with R-type sub (aluop 00001): r30 ← 3.
  - ovf_in=1 with mul (aluop 00110): r30 ← 4.
  - ovf_in=1 with div (aluop 00111): r30 ← 5.
  - Any other ovf_in=1 is ignored; normal decode applies.
  - R-type (op 00000) or addi (00101): rd ← o_in.
  - lw (01000): rd ← d_in.
  - jal (00011): r31 ← pc_in + 1, 32-bit wrap.
  - setx (10101): r30 ← {5'b0, T}.
  - All other opcodes (sw, j, bne, jr, blt, bex, unknown) and ins_in=0: no write.
- r0 is hardwired to 0.
  - A write with wb_rd=0 drives wb_we=0 and changes nothing.
  - Reads of r0 always return 0.
- Read port: if wb_we=1 and rsN_addr==wb_rd, rsN_data=wb_data (write-through). Otherwise rsN_data is the stored register. The two ports are independent.
- retired_count increments by 1 on every rising edge where ins_in≠0, whether or not a write occurs. It wraps from 0xFFFFFFFF to 0.

## Timing

- Write latency: the register updates on the rising edge at the end of the cycle in which the instruction is presented. Through write-through, the value is visible on the read ports in that same cycle.
- wb_we, wb_rd and wb_data are purely combinational from the *_in inputs.
- Reset:
  - resetn=0 asynchronously clears all 32 registers and retired_count to 0, without waiting for clk.
  - While resetn=0, no write or count occurs. Read ports return 0, except for bypass of the current combinational write, which is suppressed: wb_we is forced to 0.
  - Deassertion is sampled at the next rising edge; the first edge with resetn=1 performs normal writeback.
- A reset asserted mid-stream discards the pending write of the instruction currently presented.
- Back-to-back writes to the same register: each edge commits the current instruction. There is no ordering hazard inside the block.

## Test plan

- Reset: drive resetn=0 asynchronously between edges -> all reads 0 and retired_count=0 immediately. Release, then addi r5 with o_in=7 -> rs1_addr=5 reads 7 in the same cycle and after the edge.
- Overflow priority: add rd=3, o_in=0x80000000, ovf_in=1 -> r30=1, r3 unchanged. Repeat for addi/sub/mul/div -> r30 = 2/3/4/5.
- jal with pc_in=0xFFFFFFFF -> r31=0. setx T=0x7FFFFFF -> r30=0x07FFFFFF.
- lw rd=9, d_in=0xDEADBEEF, o_in=0x1234 -> r9=0xDEADBEEF. sw/bne/j with rd=9 -> r9 unchanged, wb_we=0.
- r0: addi rd=0, o_in=5 -> wb_we=0, r0 reads 0. Both ports addressing the same register read the identical bypassed value.
- Counter: 10 instructions interleaved with 4 nops -> retired_count=10. Preload by running 2^32-1 retirements (or force via backdoor to 0xFFFFFFFF), one more -> 0.
